// File: rtl/cp0_pkg.sv
// Shared encodings for the coprocessor-0 trap controller.
package cp0_pkg;

    localparam logic [2:0] CAUSE_OVF  = 3'b001;
    localparam logic [2:0] CAUSE_PRIV = 3'b010;
    localparam logic [2:0] CAUSE_ILL  = 3'b011;
    localparam logic [2:0] CAUSE_IRQ  = 3'b100;

    localparam logic [1:0] SEL_EPC    = 2'd0;
    localparam logic [1:0] SEL_CAUSE  = 2'd1;
    localparam logic [1:0] SEL_STATUS = 2'd2;

    typedef enum logic [1:0] {
        USER   = 2'd0,
        ENTER  = 2'd1,
        KERNEL = 2'd2
    } cp0_state_e;

endpackage

// File: rtl/cp0_trap_ctrl_irq_prio_enc.sv
// Fixed-priority encoder over the masked interrupt vector; lowest index wins.
module irq_prio_enc #(
    parameter int NIRQ = 4
) (
    input  logic [NIRQ-1:0] req,
    output logic            valid,
    output logic [7:0]      idx,
    output logic [NIRQ-1:0] grant
);

    always_comb begin
        valid = 1'b0;
        idx   = 8'd0;
        grant = '0;
        // Scan downward so the last hit (lowest index) is what remains.
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid    = 1'b1;
                idx      = 8'(i);
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_trap_ctrl.sv
// Coprocessor-0 exception/interrupt sequencer owning EPC, CAUSE and STATUS.
module cp0_trap_ctrl
    import cp0_pkg::*;
#(
    parameter int              WIDTH  = 32,
    parameter int              NIRQ   = 4,
    parameter logic [WIDTH-1:0] VECTOR = 32'h0000_0180
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc,
    input  logic             cause_write,
    input  logic [2:0]       int_cause,
    input  logic             exit_kernel,
    input  logic             write_c0,
    input  logic [1:0]       c0_sel,
    input  logic [WIDTH-1:0] c0_wdata,
    input  logic [NIRQ-1:0]  ext_irq,
    output logic             kernel_mode,
    output logic             trap,
    output logic [WIDTH-1:0] trap_pc,
    output logic             stall,
    output logic [WIDTH-1:0] c0_rdata,
    output logic [NIRQ-1:0]  irq_ack
);

    cp0_state_e       state, state_nxt;
    logic [WIDTH-1:0] epc, cause;
    logic [NIRQ-1:0]  status;

    logic             irq_valid;
    logic [7:0]       irq_idx;
    logic [NIRQ-1:0]  irq_grant;
    logic [WIDTH-1:0] exc_cause, irq_cause, status_ext;

    irq_prio_enc #(.NIRQ(NIRQ)) u_prio (
        .req   (ext_irq & status),
        .valid (irq_valid),
        .idx   (irq_idx),
        .grant (irq_grant)
    );

    always_comb begin
        exc_cause          = '0;
        exc_cause[2:0]     = int_cause;
        irq_cause          = '0;
        irq_cause[2:0]     = CAUSE_IRQ;
        irq_cause[15:8]    = irq_idx;
        status_ext         = '0;
        status_ext[NIRQ-1:0] = status;
    end

    assign trap_pc = VECTOR;

    always_comb begin
        state_nxt   = state;
        kernel_mode = 1'b0;
        trap        = 1'b0;
        stall       = 1'b0;
        irq_ack     = '0;
        case (state)
            USER: begin
                // Synchronous faults win; a pending irq is simply left pending.
                if (cause_write) begin
                    trap      = 1'b1;
                    stall     = 1'b1;
                    state_nxt = ENTER;
                end else if (irq_valid) begin
                    trap      = 1'b1;
                    stall     = 1'b1;
                    irq_ack   = irq_grant;
                    state_nxt = ENTER;
                end
            end
            ENTER: begin
                kernel_mode = 1'b1;
                stall       = 1'b1;
                state_nxt   = KERNEL;
            end
            KERNEL: begin
                kernel_mode = 1'b1;
                if (cause_write) begin
                    trap      = 1'b1;
                    stall     = 1'b1;
                    state_nxt = ENTER;
                end else if (exit_kernel) begin
                    state_nxt = USER;
                end
            end
            default: state_nxt = USER;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= USER;
            epc    <= '0;
            cause  <= '0;
            status <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                USER: begin
                    if (cause_write) begin
                        epc   <= pc;
                        cause <= exc_cause;
                    end else if (irq_valid) begin
                        epc   <= pc;
                        cause <= irq_cause;
                    end
                end
                KERNEL: begin
                    // Nested fault keeps the original EPC so the outer return survives.
                    if (cause_write) begin
                        cause <= exc_cause;
                    end else if (write_c0) begin
                        case (c0_sel)
                            SEL_EPC:    epc    <= c0_wdata;
                            SEL_CAUSE:  cause  <= c0_wdata;
                            SEL_STATUS: status <= c0_wdata[NIRQ-1:0];
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (c0_sel)
            SEL_EPC:    c0_rdata = epc;
            SEL_CAUSE:  c0_rdata = cause;
            SEL_STATUS: c0_rdata = status_ext;
            default:    c0_rdata = '0;
        endcase
    end

endmodule

// File: doc/cp0_trap_ctrl.md
Name: cp0_trap_ctrl

Overview:
- Coprocessor-0 exception/interrupt sequencer. Consumes the decoder's cause_write / int_cause / exit_kernel / write_c0 outputs plus external interrupt lines, and owns EPC, CAUSE and STATUS.
- Drives kernel_mode back to the decoder.
- Issues a one-cycle PC redirect to the trap vector, with stall.
- Sits beside the PC register and register file in the single-cycle datapath.

Parameters:
- WIDTH, 32, datapath/PC width.
- NIRQ, 4, number of external interrupt lines (1..8).
- VECTOR, 32'h0000_0180, trap handler address.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- pc  in  WIDTH  address of the instruction currently executing.
- cause_write  in  1  decoder reports a synchronous exception this cycle.
- int_cause  in  3  exception code (001 overflow, 010 privileged, 011 illegal).
- exit_kernel  in  1  return-from-kernel instruction executing.
- write_c0  in  1  move-to-c0 instruction executing.
- c0_sel  in  2  c0 register select: 0 EPC, 1 CAUSE, 2 STATUS, 3 reserved.
- c0_wdata  in  WIDTH  write data for write_c0.
- ext_irq  in  NIRQ  level-sensitive interrupt requests.
- kernel_mode  out  1  1 while in ENTER or KERNEL.
- trap  out  1  one-cycle pulse; PC loads trap_pc on the next edge.
- trap_pc  out  WIDTH  constant VECTOR.
- stall  out  1  suppresses regwrite/memwrite of the current instruction.
- c0_rdata  out  WIDTH  combinational read of the register chosen by c0_sel; reserved reads 0.
- irq_ack  out  NIRQ  one-hot pulse, asserted in the cycle the interrupt is taken.

Behaviour:
- States: USER, ENTER, KERNEL.
- Reset (async): state USER, EPC=0, CAUSE=0, STATUS=0 (all interrupts masked), outputs kernel_mode=0, trap=0, stall=0, irq_ack=0.
- Reset asserted mid-ENTER or mid-KERNEL aborts immediately to the reset state.
- irq_pending = ext_irq & STATUS[NIRQ-1:0]. The winner is the lowest set index (priority encoder).
- USER, cause_write=1:
  - EPC<=pc, CAUSE<={0, int_cause}.
  - trap=1 and stall=1 combinationally this cycle; next state ENTER.
  - Synchronous exceptions beat interrupts; pending irqs are not acked and remain pending.
- USER, cause_write=0 and irq_pending!=0:
  - EPC<=pc, CAUSE[2:0]<=3'b100, CAUSE[15:8]<=winning index.
  - irq_ack[index]=1, trap=1, stall=1; next state ENTER.
- USER otherwise: no action. write_c0 and exit_kernel in USER are ignored, because the decoder already flags them as privileged.
- ENTER: exactly one cycle; kernel_mode=1, stall=1 (the redirected fetch is discarded), trap=0; next state KERNEL. All inputs are ignored.
- KERNEL:
  - Interrupts are never taken.
  - write_c0=1 writes c0_wdata into the selected register on this edge. For STATUS only bits [NIRQ-1:0] are stored; the rest read 0.
  - exit_kernel=1: next state USER, kernel_mode drops the following cycle. The PC return via jump_reg from EPC is the datapath's job.
  - write_c0 and exit_kernel in the same cycle: the write commits, then exit.
  - cause_write=1 (nested fault): CAUSE updated, EPC preserved, trap=1, stall=1, next state ENTER. This has priority over exit_kernel and write_c0, which are both dropped.
- trap is never asserted two consecutive cycles.
- irq_ack is only asserted together with trap.
- Latency: the exception/irq is recognised in cycle N; PC=VECTOR in cycle N+1 (ENTER); the handler executes from cycle N+2.
- c0_rdata reflects a write_c0 only after the clock edge (no bypass).

Decomposition:
- Package cp0_pkg holds:
  - cause codes (CAUSE_OVF=3'b001, CAUSE_PRIV=3'b010, CAUSE_ILL=3'b011, CAUSE_IRQ=3'b100);
  - c0_sel encodings (SEL_EPC, SEL_CAUSE, SEL_STATUS);
  - the state enum typedef (USER, ENTER, KERNEL).
- One sub-module, irq_prio_enc: parameterised NIRQ; takes the masked vector and returns valid, index and one-hot grant.

Test Plan:
- Reset mid-ENTER → next cycle kernel_mode=0, EPC=CAUSE=STATUS=0, trap=0.
- USER, pc=32'h40, cause_write=1, int_cause=001 → same cycle trap=1, stall=1; next cycle kernel_mode=1; then EPC=32'h40, CAUSE=32'h1, state KERNEL.
- KERNEL, write_c0 with c0_sel=2, c0_wdata=32'hF, and exit_kernel in the same cycle → STATUS reads 32'hF; the following cycle kernel_mode=0.
- USER with STATUS=4'b1010, ext_irq=4'b1110 at pc=32'h100 → irq_ack=4'b0010, trap=1, CAUSE=32'h0000_0104, EPC=32'h100.
- Same cycle cause_write=1 (int_cause=011) and an unmasked irq → CAUSE=32'h3, irq_ack=0; after exit_kernel the still-pending irq traps at the next USER cycle.
- KERNEL, nested cause_write with int_cause=001 → EPC unchanged, CAUSE=32'h1, trap=1; ext_irq held high in KERNEL produces no irq_ack.
